// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the instruction immediate encoder.
// Immediate-format selects match the decode-stage immediate generator.
package inst_enc_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMM_SEL_W = 3;
  localparam int unsigned OPCODE_W  = 7;

  localparam logic [IMM_SEL_W-1:0] IMM_S      = IMM_SEL_W'(0);
  localparam logic [IMM_SEL_W-1:0] IMM_B      = IMM_SEL_W'(1);
  localparam logic [IMM_SEL_W-1:0] IMM_U      = IMM_SEL_W'(2);
  localparam logic [IMM_SEL_W-1:0] IMM_J      = IMM_SEL_W'(3);
  localparam logic [IMM_SEL_W-1:0] IMM_I      = IMM_SEL_W'(4);
  localparam logic [IMM_SEL_W-1:0] IMM_I_STAR = IMM_SEL_W'(5);

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD   = OPCODE_W'(7'h03);
  localparam logic [OPCODE_W-1:0] OPCODE_OP_IMM = OPCODE_W'(7'h13);
  localparam logic [OPCODE_W-1:0] OPCODE_AUIPC  = OPCODE_W'(7'h17);
  localparam logic [OPCODE_W-1:0] OPCODE_STORE  = OPCODE_W'(7'h23);
  localparam logic [OPCODE_W-1:0] OPCODE_LUI    = OPCODE_W'(7'h37);
  localparam logic [OPCODE_W-1:0] OPCODE_BRANCH = OPCODE_W'(7'h63);
  localparam logic [OPCODE_W-1:0] OPCODE_JALR   = OPCODE_W'(7'h67);
  localparam logic [OPCODE_W-1:0] OPCODE_JAL    = OPCODE_W'(7'h6F);

  typedef struct packed {
    logic [XLEN-1:0]      base;
    logic [XLEN-1:0]      imm;
    logic [IMM_SEL_W-1:0] sel;
  } enc_req_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic            err;
  } enc_rsp_t;

  // True when imm[XLEN-1:msb] are all equal, i.e. imm is a sign extension from bit msb.
  function automatic logic fits_signed(input logic [XLEN-1:0] imm, input int unsigned msb);
    logic [XLEN-1:0] hi;
    hi = {XLEN{1'b1}} << msb;
    return ((imm & hi) == hi) || ((imm & hi) == '0);
  endfunction

endpackage

// File: rtl/imm_place.sv
// Combinational immediate scatter: places imm into the format's bit positions of base
// and flags immediates that do not fit the selected format.
module imm_place
  import inst_enc_pkg::*;
(
  input  logic [XLEN-1:0]      base,
  input  logic [XLEN-1:0]      imm,
  input  logic [IMM_SEL_W-1:0] sel,
  output logic [XLEN-1:0]      inst_c,
  output logic                 err_c
);

  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] placed;

  // Field placement and range check per format; illegal selects leave base untouched.
  always_comb begin
    mask   = '0;
    placed = '0;
    err_c  = 1'b0;
    case (sel)
      IMM_I: begin
        mask   = 32'hFFF0_0000;
        placed = {imm[11:0], 20'd0};
        err_c  = !fits_signed(imm, 11);
      end
      IMM_I_STAR: begin
        mask   = 32'h01F0_0000;
        placed = {7'd0, imm[4:0], 20'd0};
        err_c  = |imm[31:5];
      end
      IMM_S: begin
        mask   = 32'hFE00_0F80;
        placed = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        err_c  = !fits_signed(imm, 11);
      end
      IMM_B: begin
        mask   = 32'hFE00_0F80;
        placed = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        err_c  = imm[0] || !fits_signed(imm, 12);
      end
      IMM_U: begin
        mask   = 32'hFFFF_F000;
        placed = {imm[31:12], 12'd0};
        err_c  = |imm[11:0];
      end
      IMM_J: begin
        mask   = 32'hFFFF_F000;
        placed = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        err_c  = imm[0] || !fits_signed(imm, 20);
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
  end

  assign inst_c = (base & ~mask) | placed;

endmodule

// File: rtl/inst_imm_encoder.sv
// Two-stage valid/ready immediate encoder for building instruction words.
// Define INST_ENC_DROP_ERR_EN to squash errored words instead of flagging them on out_err.
module inst_imm_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ERR_CNT_W       = 8,
  parameter int unsigned SKID_EN_DEFAULT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_base,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [IMM_SEL_W-1:0] in_imm_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Full-rate path lets S1 refill in the same cycle it drains.
  localparam bit FULL_RATE = (SKID_EN_DEFAULT != 0);

  logic     s1_valid;
  enc_req_t s1_q;
  enc_rsp_t enc_c;
  logic     s2_adv;
  logic     s1_adv;
  logic     s1_load;
  logic     s2_take;
  logic     s2_err_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || (FULL_RATE && s1_adv);
  assign s1_load  = in_valid && in_ready;

  imm_place u_imm_place (
    .base   (s1_q.base),
    .imm    (s1_q.imm),
    .sel    (s1_q.sel),
    .inst_c (enc_c.inst),
    .err_c  (enc_c.err)
  );

`ifdef INST_ENC_DROP_ERR_EN
  assign s2_take  = s1_adv && !enc_c.err;
  assign s2_err_d = 1'b0;
`else
  assign s2_take  = s1_adv;
  assign s2_err_d = enc_c.err;
`endif

  // S1: request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_q     <= '{base: in_base, imm: in_imm, sel: in_imm_sel};
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2: assembled word, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s2_take;
      end
      if (s2_take) begin
        out_inst <= enc_c.inst;
        out_err  <= s2_err_d;
      end
    end
  end

  // Saturating count of errored words leaving S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s1_adv && enc_c.err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
